// File: rtl/riio_gpo_drv_ctrl.sv
// GPIO pad output sequencer: orders DO/DS and OE updates so the pad never glitches.
// Optional loopback contention check enabled by defining RIIO_GPO_LOOPBACK_CHK_EN.
module riio_gpo_drv_ctrl #(
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2,
    parameter int CHK_DLY   = 3,
    parameter int CNT_W     = 4
) (
    input  logic       CLK_I,
    input  logic       RSTN_I,
    input  logic       REQ_VALID_I,
    output logic       REQ_READY_O,
    input  logic       REQ_DATA_I,
    input  logic       REQ_OE_I,
    input  logic [1:0] REQ_DS_I,
    input  logic       OD_MODE_I,
    output logic       PAD_DO_O,
    output logic       PAD_OE_O,
    output logic [1:0] PAD_DS_O,
    input  logic       PAD_DI_I,
    output logic       BUSY_O,
    output logic       ERR_O,
    input  logic       ERR_CLR_I
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        HOLD
`ifdef RIIO_GPO_LOOPBACK_CHK_EN
        , CHECK
`endif
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_q, do_d, oe_q, oe_d;
    logic [1:0]       ds_q, ds_d;
    logic             pend_do_q, pend_do_d;
    logic [1:0]       pend_ds_q, pend_ds_d;
    logic             oe_n, do_n;
    logic             err_set;

    // Open-drain drives low by enabling the pad; a high level is released via OE.
    assign oe_n = OD_MODE_I ? ~REQ_DATA_I : REQ_OE_I;
    assign do_n = OD_MODE_I ? 1'b0 : REQ_DATA_I;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_d      = do_q;
        oe_d      = oe_q;
        ds_d      = ds_q;
        pend_do_d = pend_do_q;
        pend_ds_d = pend_ds_q;
        err_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (REQ_VALID_I) begin
                    cnt_d = '0;
                    if (!oe_q && oe_n) begin
                        do_d    = do_n;
                        ds_d    = REQ_DS_I;
                        state_d = SETUP;
                    end else if (oe_q && !oe_n) begin
                        oe_d      = 1'b0;
                        pend_do_d = do_n;
                        pend_ds_d = REQ_DS_I;
                        state_d   = HOLD;
                    end else begin
                        do_d = do_n;
                        ds_d = REQ_DS_I;
`ifdef RIIO_GPO_LOOPBACK_CHK_EN
                        if (oe_n) state_d = CHECK;
`endif
                    end
                end
            end
            SETUP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SETUP_LAST) begin
                    oe_d  = 1'b1;
                    cnt_d = '0;
`ifdef RIIO_GPO_LOOPBACK_CHK_EN
                    state_d = CHECK;
`else
                    state_d = IDLE;
`endif
                end
            end
            HOLD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == HOLD_LAST) begin
                    do_d    = pend_do_q;
                    ds_d    = pend_ds_q;
                    state_d = IDLE;
                end
            end
`ifdef RIIO_GPO_LOOPBACK_CHK_EN
            CHECK: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(CHK_DLY - 1)) begin
                    err_set = oe_q && (PAD_DI_I != do_q);
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            do_q      <= 1'b0;
            oe_q      <= 1'b0;
            ds_q      <= 2'd0;
            pend_do_q <= 1'b0;
            pend_ds_q <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            do_q      <= do_d;
            oe_q      <= oe_d;
            ds_q      <= ds_d;
            pend_do_q <= pend_do_d;
            pend_ds_q <= pend_ds_d;
        end
    end

`ifdef RIIO_GPO_LOOPBACK_CHK_EN
    logic err_q;
    // Set has priority so a contention seen in the clearing cycle is not lost.
    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I)        err_q <= 1'b0;
        else if (err_set)   err_q <= 1'b1;
        else if (ERR_CLR_I) err_q <= 1'b0;
    end
    assign ERR_O = err_q;
`else
    logic unused_ok;
    assign unused_ok = ^{PAD_DI_I, ERR_CLR_I, err_set, CNT_W'(CHK_DLY)};
    assign ERR_O     = 1'b0;
`endif

    assign REQ_READY_O = (state_q == IDLE);
    assign BUSY_O      = (state_q != IDLE);
    assign PAD_DO_O    = do_q;
    assign PAD_OE_O    = oe_q;
    assign PAD_DS_O    = ds_q;

endmodule

// File: tb/tb_riio_gpo_drv_ctrl.sv
// Self-checking bench for riio_gpo_drv_ctrl: scoreboard of expected pad states and latencies.
module tb_riio_gpo_drv_ctrl;

    localparam int SETUP = 2;
    localparam int HOLD  = 2;
    localparam int CHK   = 3;
`ifdef RIIO_GPO_LOOPBACK_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic       CLK_I = 1'b0;
    logic       RSTN_I;
    logic       REQ_VALID_I, REQ_READY_O, REQ_DATA_I, REQ_OE_I, OD_MODE_I;
    logic [1:0] REQ_DS_I, PAD_DS_O;
    logic       PAD_DO_O, PAD_OE_O, PAD_DI_I, BUSY_O, ERR_O, ERR_CLR_I;
    logic       di_force0;

    riio_gpo_drv_ctrl #(.SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .CHK_DLY(CHK), .CNT_W(4)) dut (
        .CLK_I(CLK_I), .RSTN_I(RSTN_I),
        .REQ_VALID_I(REQ_VALID_I), .REQ_READY_O(REQ_READY_O),
        .REQ_DATA_I(REQ_DATA_I), .REQ_OE_I(REQ_OE_I), .REQ_DS_I(REQ_DS_I),
        .OD_MODE_I(OD_MODE_I),
        .PAD_DO_O(PAD_DO_O), .PAD_OE_O(PAD_OE_O), .PAD_DS_O(PAD_DS_O),
        .PAD_DI_I(PAD_DI_I), .BUSY_O(BUSY_O), .ERR_O(ERR_O), .ERR_CLR_I(ERR_CLR_I)
    );

    always #5 CLK_I = ~CLK_I;
    assign PAD_DI_I = di_force0 ? 1'b0 : PAD_DO_O;

    typedef struct {
        logic       f_do, f_oe;
        logic [1:0] f_ds;
        logic       e_do, e_oe;
        logic [1:0] e_ds;
        logic       e_err;
        int         lat;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       m_do = 1'b0, m_oe = 1'b0, m_err = 1'b0;
    logic [1:0] m_ds = 2'd0;
    bit         hold_valid = 1'b0;
    bit         mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // OE must never toggle in the same cycle as DO/DS.
    logic       p_do = 1'b0, p_oe = 1'b0;
    logic [1:0] p_ds = 2'd0;
    always @(negedge CLK_I) begin
        if (mon_en)
            check("glitch", ((PAD_OE_O !== p_oe) && ((PAD_DO_O !== p_do) || (PAD_DS_O !== p_ds))), 0);
        p_do <= PAD_DO_O;
        p_oe <= PAD_OE_O;
        p_ds <= PAD_DS_O;
    end

    // Called at a negedge with the model idle; returns at the negedge after acceptance.
    task automatic drive_req(input logic data, input logic oe, input logic [1:0] ds,
                             input logic od, input logic clr);
        exp_t e;
        logic oe_n, do_n, mism;
        oe_n = od ? ~data : oe;
        do_n = od ? 1'b0 : data;
        mism = CHK_EN && oe_n && di_force0 && do_n;
        e.e_do = do_n; e.e_oe = oe_n; e.e_ds = ds;
        if (!m_oe && oe_n) begin
            e.lat = 1 + SETUP + (CHK_EN ? CHK : 0);
            e.f_do = do_n; e.f_oe = 1'b0; e.f_ds = ds;
        end else if (m_oe && !oe_n) begin
            e.lat = 1 + HOLD;
            e.f_do = m_do; e.f_oe = 1'b0; e.f_ds = m_ds;
        end else begin
            e.lat = 1 + ((CHK_EN && oe_n) ? CHK : 0);
            e.f_do = do_n; e.f_oe = oe_n; e.f_ds = ds;
        end
        e.e_err = mism ? 1'b1 : ((clr && CHK_EN) ? 1'b0 : m_err);
        m_do = do_n; m_oe = oe_n; m_ds = ds; m_err = e.e_err;
        sb_q.push_back(e);
        check("ready_at_drive", REQ_READY_O, 1);
        REQ_VALID_I = 1'b1; REQ_DATA_I = data; REQ_OE_I = oe; REQ_DS_I = ds;
        OD_MODE_I = od; ERR_CLR_I = clr;
        @(posedge CLK_I);
        @(negedge CLK_I);
        if (!hold_valid) REQ_VALID_I = 1'b0;
        REQ_DATA_I = ~data; REQ_OE_I = ~oe; REQ_DS_I = ~ds; OD_MODE_I = ~od;
    endtask

    // Pops the scoreboard and follows the transaction until READY returns.
    task automatic finish_req();
        exp_t e;
        e = sb_q.pop_front();
        check("first_do", PAD_DO_O, e.f_do);
        check("first_oe", PAD_OE_O, e.f_oe);
        check("first_ds", PAD_DS_O, e.f_ds);
        for (int k = 1; k <= e.lat; k++) begin
            if (k > 1) @(negedge CLK_I);
            check("ready", REQ_READY_O, (k == e.lat));
            check("busy", BUSY_O, (k != e.lat));
        end
        check("final_do", PAD_DO_O, e.e_do);
        check("final_oe", PAD_OE_O, e.e_oe);
        check("final_ds", PAD_DS_O, e.e_ds);
        check("final_err", ERR_O, e.e_err);
        ERR_CLR_I = 1'b0;
    endtask

    task automatic req(input logic data, input logic oe, input logic [1:0] ds,
                       input logic od, input logic clr);
        drive_req(data, oe, ds, od, clr);
        finish_req();
    endtask

    task automatic clear_err();
        ERR_CLR_I = 1'b1;
        @(posedge CLK_I);
        @(negedge CLK_I);
        ERR_CLR_I = 1'b0;
        m_err = 1'b0;
        check("err_cleared", ERR_O, 0);
    endtask

    initial begin
        RSTN_I = 1'b0; REQ_VALID_I = 1'b0; REQ_DATA_I = 1'b0; REQ_OE_I = 1'b0;
        REQ_DS_I = 2'd0; OD_MODE_I = 1'b0; ERR_CLR_I = 1'b0; di_force0 = 1'b0;
        repeat (3) @(negedge CLK_I);
        check("rst_do", PAD_DO_O, 0);
        check("rst_oe", PAD_OE_O, 0);
        check("rst_ds", PAD_DS_O, 0);
        check("rst_err", ERR_O, 0);
        check("rst_busy", BUSY_O, 0);
        RSTN_I = 1'b1;
        @(negedge CLK_I);
        mon_en = 1'b1;
        check("rel_ready", REQ_READY_O, 1);

        // Reset while the SETUP phase is pending.
        drive_req(1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
        check("mid_setup_do", PAD_DO_O, 1);
        check("mid_setup_oe", PAD_OE_O, 0);
        void'(sb_q.pop_front());
        #2 RSTN_I = 1'b0;
        #1;
        check("async_rst_do", PAD_DO_O, 0);
        check("async_rst_oe", PAD_OE_O, 0);
        check("async_rst_ds", PAD_DS_O, 0);
        check("async_rst_busy", BUSY_O, 0);
        @(negedge CLK_I);
        RSTN_I = 1'b1;
        m_do = 1'b0; m_oe = 1'b0; m_ds = 2'd0; m_err = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK_I);
            check("post_rst_oe", PAD_OE_O, 0);
            check("post_rst_ready", REQ_READY_O, 1);
        end

        // Directed sequence: rise, same-OE update, fall, OE-off update, open-drain.
        req(1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
        req(1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
        req(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        req(1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
        req(1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
        req(1'b0, 1'b0, 2'd2, 1'b1, 1'b0);
        req(1'b1, 1'b1, 2'd2, 1'b1, 1'b0);

        // Contention: DI stuck low while driving high.
        di_force0 = 1'b1;
        req(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
        clear_err();
        req(1'b1, 1'b1, 2'd2, 1'b0, 1'b1);
        di_force0 = 1'b0;
        clear_err();
        req(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        // VALID held high across back-to-back requests with alternating OE.
        for (int i = 0; i < 10; i++) begin
            hold_valid = (i != 9);
            req(1'($urandom_range(0, 1)), ~i[0], 2'($urandom_range(0, 3)), 1'b0, 1'b0);
        end
        hold_valid = 1'b0;

        // Random mix including open-drain requests.
        for (int i = 0; i < 20; i++)
            req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);

        repeat (2) @(negedge CLK_I);
        check("end_ready", REQ_READY_O, 1);
        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riio_gpo_drv_ctrl.md
# riio_gpo_drv_ctrl

Digital output-side controller for a general-purpose I/O pad: the transmit counterpart to the pull-down input receiver. Accepts drive requests from core logic over a valid/ready handshake and sequences the pad's data, output-enable and drive-strength controls glitch-free: data settles before OE rises, and OE falls before data changes. Optionally reads back the receiver's DI to flag pad contention. Sits in the core voltage domain directly in front of the pad cell.

## Interface
- SETUP_CYC, 2: cycles PAD_DO_O/PAD_DS_O are stable before PAD_OE_O rises; legal range ≥1.
- HOLD_CYC, 2: cycles after PAD_OE_O falls before PAD_DO_O/PAD_DS_O may change; legal range ≥1.
- CHK_DLY, 3: settle cycles before loopback compare; legal range ≥1.
- CNT_W, 4: counter width; 2^CNT_W > max(SETUP_CYC, HOLD_CYC, CHK_DLY).

Ports (name, direction, width, meaning):
- CLK_I  in  1  clock.
- RSTN_I  in  1  reset; asynchronous, active-low.
- REQ_VALID_I  in  1  request valid.
- REQ_READY_O  out  1  request accepted when high with VALID.
- REQ_DATA_I  in  1  requested pad level.
- REQ_OE_I  in  1  requested output enable (ignored in open-drain mode).
- REQ_DS_I  in  2  requested drive strength.
- OD_MODE_I  in  1  open-drain mode; sampled at acceptance only.
- PAD_DO_O  out  1  pad data.
- PAD_OE_O  out  1  pad output enable.
- PAD_DS_O  out  2  pad drive strength.
- PAD_DI_I  in  1  receiver data (DI bit 0) for loopback.
- BUSY_O  out  1  high whenever state ≠ IDLE.
- ERR_O  out  1  sticky contention flag.
- ERR_CLR_I  in  1  clears ERR_O.

## Operation
- Effective request at acceptance: OD_MODE_I=1 → oe_n=~REQ_DATA_I, do_n=0; else oe_n=REQ_OE_I, do_n=REQ_DATA_I. ds_n=REQ_DS_I.
- States: IDLE, SETUP, HOLD, CHECK. REQ_READY_O=1 only in IDLE.
- IDLE, accept with PAD_OE_O=0, oe_n=1: load DO/DS, go SETUP.
- IDLE, accept with PAD_OE_O=1, oe_n=0: clear OE, go HOLD.
- IDLE, accept with OE unchanged: load DO/DS directly; if resulting OE=1 and check enabled go CHECK, else stay IDLE.
- SETUP: count SETUP_CYC cycles, then set OE=1; go CHECK (check enabled) or IDLE.
- HOLD: count HOLD_CYC cycles, then load DO/DS; go IDLE.
- CHECK: count CHK_DLY cycles; on last cycle compare PAD_DI_I with PAD_DO_O while PAD_OE_O=1; mismatch sets ERR_O; go IDLE.
- ERR_O sticky; ERR_CLR_I clears it; simultaneous set and clear → set wins.
- REQ_* inputs are ignored outside the accepting cycle; VALID held while not ready is not consumed.

## Timing
- Reset (async, any state): PAD_DO_O=0, PAD_OE_O=0, PAD_DS_O=0, ERR_O=0, BUSY_O=0, state IDLE, REQ_READY_O=1 after reset release; an in-flight request is discarded.
- Accept at edge t. Same-OE update: outputs change at t+1; READY high at t+1 (no check).
- OE 0→1: DO/DS at t+1, OE at t+1+SETUP_CYC; READY at t+1+SETUP_CYC (no check).
- OE 1→0: OE low at t+1, DO/DS at t+1+HOLD_CYC; READY at t+1+HOLD_CYC.
- CHECK adds CHK_DLY cycles after final OE=1 update; compare on the last cycle; ERR_O registered next edge, same edge READY returns.
- Back-to-back: new request accepted in the same cycle READY reasserts.
- PAD_OE_O never rises in the same cycle PAD_DO_O/PAD_DS_O changes, nor vice versa.

## Configuration
- RIIO_GPO_LOOPBACK_CHK_EN defined: CHECK state present, PAD_DI_I compared, ERR_O/ERR_CLR_I active.
- Not defined: no CHECK state (transitions go to IDLE), PAD_DI_I and ERR_CLR_I unused, ERR_O tied 0, CHK_DLY ignored.

## Test plan
- Reset mid-SETUP (DO=1 driven, OE pending) → all pad outputs 0 immediately, READY=1 after release, OE never rises.
- From OE=0, request DATA=1 OE=1 DS=2, defaults → DO=1, DS=2 at t+1; OE=1 at t+3; READY=0 t+1..t+2 (+3 CHK cycles with macro).
- From OE=1 DO=1, request OE=0 DATA=0 → OE=0 at t+1, DO=0 at t+3, never DO change while OE=1.
- OD mode, DATA=0 then DATA=1 → first: DO=0, OE=1 after setup; second: OE=0 at t+1, DO stays 0.
- Macro on, drive 1 with PAD_DI_I forced 0 → ERR_O=1 after CHK_DLY; ERR_CLR_I pulse clears it; clear coincident with new mismatch keeps ERR_O=1.
- VALID held continuously with alternating OE → each accepted only while READY=1, no request lost or duplicated.
